// File: rtl/obi_rr_arbiter.sv
// rtl/obi_rr_arbiter.sv - OBI N:1 arbiter with address-phase lock and in-order response routing
// Optional feature macro: OBI_ARB_FIXED_PRIO_EN (fixed lowest-index priority instead of round-robin)
module obi_rr_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int OBI_ADDRW = 32,
  parameter int OBI_DATAW = 32,
  parameter int OBI_STRBW = OBI_DATAW / 8,
  parameter int MAX_OUTST = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_REQ-1:0]                   req_i,
  input  logic [NUM_REQ-1:0]                   we_i,
  input  logic [NUM_REQ-1:0][OBI_ADDRW-1:0]    addr_i,
  input  logic [NUM_REQ-1:0][OBI_DATAW-1:0]    wdata_i,
  input  logic [NUM_REQ-1:0][OBI_STRBW-1:0]    be_i,
  output logic [NUM_REQ-1:0]                   gnt_o,
  output logic [NUM_REQ-1:0]                   rvalid_o,
  output logic [OBI_DATAW-1:0]                 rdata_o,
  output logic                                 m_req_o,
  output logic                                 m_we_o,
  output logic [OBI_ADDRW-1:0]                 m_addr_o,
  output logic [OBI_DATAW-1:0]                 m_wdata_o,
  output logic [OBI_STRBW-1:0]                 m_be_o,
  input  logic                                 m_gnt_i,
  input  logic                                 m_rvalid_i,
  input  logic [OBI_DATAW-1:0]                 m_rdata_i,
  output logic                                 err_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(MAX_OUTST);
  localparam int CW  = PW + 1;

  logic           lock;
  logic [IDW-1:0] lock_idx;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] sel_free;
  logic           found;
  logic           full;
  logic           grant;
  logic           pop;

  logic [IDW-1:0] mem [MAX_OUTST];
  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic [CW-1:0]  count;
  logic [IDW-1:0] head;

`ifdef OBI_ARB_FIXED_PRIO_EN
  // Unlocked choice: lowest-index active requester
  always_comb begin
    sel_free = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i]) begin
        sel_free = IDW'(i);
        found    = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0]   rr_ptr;
  logic [2*NUM_REQ-1:0] rot;
  logic [IDW:0]     sum;

  // Unlocked choice: first active requester at or above rr_ptr, wrapping
  always_comb begin
    sel_free = rr_ptr;
    found    = 1'b0;
    sum      = '0;
    rot      = {req_i, req_i} >> rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
      if (!found && rot[i]) begin
        sel_free = sum[IDW-1:0];
        found    = 1'b1;
      end
    end
  end

  // Priority moves just past the requester that won the last grant
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (sel == IDW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    end
  end
`endif

  assign sel       = lock ? lock_idx : sel_free;
  assign full      = (count == CW'(MAX_OUTST));
  assign m_req_o   = req_i[sel] & ~full;
  assign m_we_o    = we_i[sel];
  assign m_addr_o  = addr_i[sel];
  assign m_wdata_o = wdata_i[sel];
  assign m_be_o    = be_i[sel];
  assign grant     = m_req_o & m_gnt_i;
  assign pop       = m_rvalid_i & (count != '0);
  assign head      = mem[rptr];
  assign rdata_o   = m_rdata_i;

  // Grant and response fan-out to the owning requester
  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (grant) gnt_o[sel] = 1'b1;
    if (pop)   rvalid_o[head] = 1'b1;
  end

  // Hold the selection while an offered request waits for its grant
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (grant) begin
      lock <= 1'b0;
    end else if (m_req_o) begin
      lock     <= 1'b1;
      lock_idx <= sel;
    end
  end

  // ID FIFO storage; head is read before a same-cycle push lands
  always_ff @(posedge clk_i) begin
    if (grant) mem[wptr] <= sel;
  end

  // ID FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (grant) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      count <= count + CW'(grant) - CW'(pop);
    end
  end

  // Sticky flag for a response nobody is waiting for
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (m_rvalid_i && count == '0) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// tb/tb_obi_rr_arbiter.sv - directed self-checking bench for obi_rr_arbiter
module tb_obi_rr_arbiter;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [1:0]       req_i;
  logic [1:0]       we_i;
  logic [1:0][31:0] addr_i;
  logic [1:0][31:0] wdata_i;
  logic [1:0][3:0]  be_i;
  logic [1:0]       gnt_o;
  logic [1:0]       rvalid_o;
  logic [31:0]      rdata_o;
  logic             m_req_o;
  logic             m_we_o;
  logic [31:0]      m_addr_o;
  logic [31:0]      m_wdata_o;
  logic [3:0]       m_be_o;
  logic             m_gnt_i;
  logic             m_rvalid_i;
  logic [31:0]      m_rdata_i;
  logic             err_o;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0000;

  obi_rr_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_be_o(m_be_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drive inputs just after a rising edge, then settle to the falling edge for checks
  task automatic drive(input logic [1:0] r, input logic g, input logic v, input logic [31:0] d);
    req_i = r; m_gnt_i = g; m_rvalid_i = v; m_rdata_i = d;
    @(negedge clk_i);
  endtask

  task automatic adv();
    @(posedge clk_i); #1;
  endtask

  task automatic grant_step(input string tag, input logic [1:0] r, input logic [1:0] exp_gnt,
                            input logic [31:0] exp_addr);
    drive(r, 1'b1, 1'b0, 32'h0);
    chk({tag, "_gnt"}, {30'b0, gnt_o}, {30'b0, exp_gnt});
    chk({tag, "_addr"}, m_addr_o, exp_addr);
    adv();
  endtask

  task automatic resp_step(input string tag, input logic [1:0] exp_rv, input logic [31:0] d);
    drive(2'b00, 1'b0, 1'b1, d);
    chk({tag, "_rvalid"}, {30'b0, rvalid_o}, {30'b0, exp_rv});
    chk({tag, "_rdata"}, rdata_o, d);
    adv();
  endtask

  initial begin
    rst_ni = 1'b0;
    we_i = 2'b01;
    addr_i = {A1, A0};
    wdata_i = {32'hBBBB_0001, 32'hAAAA_0000};
    be_i = {4'h3, 4'hC};
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    adv();
    @(negedge clk_i);
    chk("rst_gnt", {30'b0, gnt_o}, 32'h0);
    chk("rst_rvalid", {30'b0, rvalid_o}, 32'h0);
    chk("rst_mreq", {31'b0, m_req_o}, 32'h0);
    chk("rst_err", {31'b0, err_o}, 32'h0);
    adv();
    rst_ni = 1'b1;

`ifdef OBI_ARB_FIXED_PRIO_EN
    grant_step("fp0", 2'b11, 2'b01, A0);
    grant_step("fp1", 2'b11, 2'b01, A0);
    grant_step("fp2", 2'b11, 2'b01, A0);
    grant_step("fp3", 2'b10, 2'b10, A1);
    resp_step("fpr0", 2'b01, 32'h11);
    resp_step("fpr1", 2'b01, 32'h12);
    resp_step("fpr2", 2'b01, 32'h13);
    resp_step("fpr3", 2'b10, 32'h14);
`else
    // alternating grants with both requesting
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    chk("rr0_gnt", {30'b0, gnt_o}, 32'h1);
    chk("rr0_addr", m_addr_o, A0);
    chk("rr0_we", {31'b0, m_we_o}, 32'h1);
    chk("rr0_be", {28'b0, m_be_o}, 32'hC);
    adv();
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    chk("rr1_gnt", {30'b0, gnt_o}, 32'h2);
    chk("rr1_addr", m_addr_o, A1);
    chk("rr1_we", {31'b0, m_we_o}, 32'h0);
    chk("rr1_wdata", m_wdata_o, 32'hBBBB_0001);
    adv();
    grant_step("rr2", 2'b11, 2'b01, A0);
    grant_step("rr3", 2'b11, 2'b10, A1);
    resp_step("rrr0", 2'b01, 32'hD000_0000);
    resp_step("rrr1", 2'b10, 32'hD000_0001);
    resp_step("rrr2", 2'b01, 32'hD000_0002);
    resp_step("rrr3", 2'b10, 32'hD000_0003);

    // lock: rr_ptr at 1 after a grant to 0, then 0 waits without grant
    grant_step("lk_pre", 2'b01, 2'b01, A0);
    for (int c = 0; c < 3; c++) begin
      drive((c == 0) ? 2'b01 : 2'b11, 1'b0, 1'b0, 32'h0);
      chk("lk_hold_addr", m_addr_o, A0);
      chk("lk_hold_req", {31'b0, m_req_o}, 32'h1);
      chk("lk_hold_gnt", {30'b0, gnt_o}, 32'h0);
      adv();
    end
    grant_step("lk_gnt", 2'b11, 2'b01, A0);
    grant_step("lk_next", 2'b11, 2'b10, A1);
    resp_step("lkr0", 2'b01, 32'h21);
    resp_step("lkr1", 2'b01, 32'h22);
    resp_step("lkr2", 2'b10, 32'h23);

    // full: four grants, fifth blocked; a response frees a slot next cycle
    grant_step("fu0", 2'b11, 2'b01, A0);
    grant_step("fu1", 2'b11, 2'b10, A1);
    grant_step("fu2", 2'b11, 2'b01, A0);
    grant_step("fu3", 2'b11, 2'b10, A1);
    drive(2'b11, 1'b1, 1'b1, 32'h31);
    chk("fu_blocked_req", {31'b0, m_req_o}, 32'h0);
    chk("fu_blocked_gnt", {30'b0, gnt_o}, 32'h0);
    chk("fu_resp", {30'b0, rvalid_o}, 32'h1);
    adv();
    grant_step("fu_again", 2'b11, 2'b01, A0);
    resp_step("fur0", 2'b10, 32'h32);
    resp_step("fur1", 2'b01, 32'h33);
    resp_step("fur2", 2'b10, 32'h34);
    resp_step("fur3", 2'b01, 32'h35);

    // simultaneous grant and response with one outstanding owned by 1
    grant_step("sim_pre", 2'b10, 2'b10, A1);
    drive(2'b01, 1'b1, 1'b1, 32'h41);
    chk("sim_gnt", {30'b0, gnt_o}, 32'h1);
    chk("sim_rvalid", {30'b0, rvalid_o}, 32'h2);
    adv();
    resp_step("sim_next", 2'b01, 32'h42);
    chk("sim_err", {31'b0, err_o}, 32'h0);
`endif

    // unexpected response sets a sticky error
    drive(2'b00, 1'b0, 1'b1, 32'h51);
    chk("err_rvalid", {30'b0, rvalid_o}, 32'h0);
    adv();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    chk("err_set", {31'b0, err_o}, 32'h1);
    adv();
    adv();
    @(negedge clk_i);
    chk("err_sticky", {31'b0, err_o}, 32'h1);
    adv();
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("err_before_edge", {31'b0, err_o}, 32'h1);
    adv();
    @(negedge clk_i);
    chk("err_cleared", {31'b0, err_o}, 32'h0);
    adv();
    rst_ni = 1'b1;

    // reset mid-operation drops the outstanding ID
    grant_step("rd_pre", 2'b01, 2'b01, A0);
    rst_ni = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    adv();
    rst_ni = 1'b1;
    drive(2'b00, 1'b0, 1'b1, 32'h61);
    chk("rd_rvalid", {30'b0, rvalid_o}, 32'h0);
    adv();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    chk("rd_err", {31'b0, err_o}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
